io_arb: RTL and testbench
=========================

IO_ARB -- requirements
Module: io_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, IO data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, IO address width.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0/req1  input  1  requester N transaction request.
REQ-006 SHALL have ports addr0/addr1  input  ADDR_WIDTH  requester N target address.
REQ-007 SHALL have ports wdata0/wdata1  input  DATA_WIDTH  requester N write data.
REQ-008 SHALL have ports we0/we1 and rd0/rd1  input  1  requester N write / read select.
REQ-009 SHALL have ports lock0/lock1  input  1  requester N keep-bus hint.
REQ-010 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse to requester N.
REQ-011 SHALL have ports rdata0/rdata1  output  DATA_WIDTH  read data captured for requester N.
REQ-012 SHALL have ports io_addr  output  ADDR_WIDTH, io_dout  output  DATA_WIDTH, io_we  output  1, io_rd  output  1  shared IO bus to peripheral unit.
REQ-013 SHALL have port io_din  input  DATA_WIDTH  peripheral read data, combinational from io_addr.
REQ-014 SHALL have ports busy  output  1  (FSM not IDLE) and gnt  output  1  (index of current/last granted requester).

Function
REQ-015 SHALL implement FSM IDLE -> XFER -> DONE -> IDLE; no other states.
REQ-016 In IDLE with any req high SHALL select one requester, register its addr/wdata/we/rd, set gnt, enter XFER next cycle.
REQ-017 Arbitration SHALL be round-robin: on simultaneous req0 and req1, grant the requester not granted last; single request granted directly.
REQ-018 In XFER (exactly one cycle) SHALL drive io_addr/io_dout from registered values and assert io_we or io_rd; all IO outputs SHALL be 0 in IDLE and DONE.
REQ-019 If both we and rd are set in a request, SHALL perform write only (io_rd held 0).
REQ-020 A request with neither we nor rd SHALL still pass through XFER and be acked, with no io_we/io_rd pulse.
REQ-021 On a read, SHALL capture io_din into rdataN of granted requester at end of XFER; rdata of the other requester SHALL hold.
REQ-022 In DONE SHALL pulse ackN for exactly one cycle for the granted requester, then return to IDLE.
REQ-023 Latency: req sampled in IDLE at cycle 0 -> io_we/io_rd at cycle 1 -> ack at cycle 2; minimum 3 cycles between grants.
REQ-024 Requester SHALL hold req and operands stable until ack; req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-025 req changes during XFER/DONE SHALL not affect the current transaction.
REQ-026 Round-robin pointer SHALL update in DONE to the requester just served.

Reset
REQ-027 rstn low SHALL asynchronously force IDLE, io_we=io_rd=0, io_addr=io_dout=0, ack0=ack1=0, busy=0.
REQ-028 Reset SHALL set rdata0=rdata1=0, gnt=0, and the pointer so requester 0 wins the first contention.
REQ-029 Reset mid-transaction SHALL abort it with no ack issued and no further IO strobe.

Configuration
REQ-030 With macro IO_ARB_LOCK_EN defined: if the granted requester has lock high in DONE and its req high in the next IDLE, it SHALL be re-granted regardless of round-robin; req low in that IDLE releases the lock.
REQ-031 Without IO_ARB_LOCK_EN: lock0/lock1 SHALL remain ports but be ignored; pure round-robin.

Verification
REQ-032 Reset, then req0 write addr 0x00 data 0x0000_A5A5 -> io_we=1, io_addr=0x00, io_dout=0x0000_A5A5 at cycle 1; ack0 at cycle 2; no ack1.
REQ-033 req1 read addr 0x14 with io_din=0x0000_1234 -> io_rd one cycle, rdata1=0x0000_1234 with ack1; rdata0 unchanged.
REQ-034 req0 and req1 held high continuously -> grants alternate 0,1,0,1, each ack 3 cycles apart.
REQ-035 IO_ARB_LOCK_EN defined, req0+lock0 and req1 high -> requester 0 granted repeatedly; lock0 low -> requester 1 granted next; macro undefined -> alternation as REQ-034.
REQ-036 rstn pulsed low during XFER -> io_we/io_rd drop immediately, no ack, busy=0; next request served normally.
REQ-037 req0 with we=rd=1 to addr 0x18 -> io_we pulse only, io_rd stays 0, ack0 issued.

Source files
------------

// File: rtl/io_arb.sv
// rtl/io_arb.sv - two-requester round-robin arbiter onto a shared single-cycle IO bus
// Optional macro IO_ARB_LOCK_EN: a locked requester may keep the bus across back-to-back grants.
module io_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  rd0,
  input  logic                  rd1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] io_addr,
  output logic [DATA_WIDTH-1:0] io_dout,
  output logic                  io_we,
  output logic                  io_rd,
  input  logic [DATA_WIDTH-1:0] io_din,
  output logic                  busy,
  output logic                  gnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  lock_hold_q, lock_hold_d;
  logic                  sel;
  logic                  xfer;

`ifdef IO_ARB_LOCK_EN
  logic                  lock_owner_req;
  assign lock_owner_req = gnt_q ? req1 : req0;
`else
  logic                  unused_lock;
  assign unused_lock = lock0 ^ lock1;
`endif

  // Contention goes to the requester not served last, unless a held lock claims the bus.
  always_comb begin
    sel = 1'b0;
`ifdef IO_ARB_LOCK_EN
    if (lock_hold_q && lock_owner_req)
      sel = gnt_q;
    else
`endif
    if (req0 && req1)
      sel = ~last_q;
    else
      sel = req1 & ~req0;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rd_d        = rd_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    lock_hold_d = lock_hold_q;
    case (state_q)
      S_IDLE: begin
        lock_hold_d = 1'b0;
        if (req0 || req1) begin
          state_d = S_XFER;
          gnt_d   = sel;
          addr_d  = sel ? addr1  : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          we_d    = sel ? we1    : we0;
          rd_d    = sel ? rd1    : rd0;
        end
      end
      S_XFER: begin
        state_d = S_DONE;
        if (rd_q && !we_q) begin
          if (gnt_q)
            rdata1_d = io_din;
          else
            rdata0_d = io_din;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = gnt_q;
`ifdef IO_ARB_LOCK_EN
        lock_hold_d = gnt_q ? lock1 : lock0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      lock_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      lock_hold_q <= lock_hold_d;
    end
  end

  // Bus outputs decode straight from state so an async reset kills strobes at once.
  assign xfer    = (state_q == S_XFER);
  assign io_addr = xfer ? addr_q  : '0;
  assign io_dout = xfer ? wdata_q : '0;
  assign io_we   = xfer & we_q;
  assign io_rd   = xfer & rd_q & ~we_q;
  assign ack0    = (state_q == S_DONE) & ~gnt_q;
  assign ack1    = (state_q == S_DONE) &  gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign gnt     = gnt_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_io_arb.sv
// tb/tb_io_arb.sv - self-checking bench for io_arb against a transaction-level model
// Honours IO_ARB_LOCK_EN in its model when the macro is defined.
module tb_io_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req1, we0, we1, rd0, rd1, lock0, lock1;
  logic [7:0]  addr0, addr1, io_addr;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, io_dout, io_din;
  logic        ack0, ack1, io_we, io_rd, busy, gnt;

  logic        p [2];
  logic [7:0]  a [2];
  logic [31:0] wd [2];
  logic        we_r [2];
  logic        rd_r [2];
  logic        lk [2];
  logic        din_force;
  logic [31:0] din_val;

  int          last_m;
  logic        gnt_m;
  logic        lock_act;
  logic [31:0] exp_rd [2];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] periph(input logic [7:0] x);
    return {x ^ 8'hc3, 8'h5a, x, ~x};
  endfunction

  assign io_din = din_force ? din_val : periph(io_addr);
  assign req0 = p[0];   assign req1 = p[1];
  assign addr0 = a[0];  assign addr1 = a[1];
  assign wdata0 = wd[0]; assign wdata1 = wd[1];
  assign we0 = we_r[0]; assign we1 = we_r[1];
  assign rd0 = rd_r[0]; assign rd1 = rd_r[1];
  assign lock0 = lk[0]; assign lock1 = lk[1];

  io_arb dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .rd0(rd0), .rd1(rd1), .lock0(lock0), .lock1(lock1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd),
    .io_din(io_din), .busy(busy), .gnt(gnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_m   = 1;
    gnt_m    = 1'b0;
    lock_act = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic set_req(input int r, input logic [7:0] ad, input logic [31:0] d,
                         input logic w, input logic rr, input logic l);
    p[r] = 1'b1; a[r] = ad; wd[r] = d; we_r[r] = w; rd_r[r] = rr; lk[r] = l;
  endtask

  task automatic new_req(input int r);
    set_req(r, 8'($urandom), $urandom, 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0);
  endtask

  task automatic check_idle();
    chk("idle_busy", busy, 1'b0);
    chk("idle_we", io_we, 1'b0);
    chk("idle_rd", io_rd, 1'b0);
    chk("idle_addr", io_addr, 8'h0);
    chk("idle_dout", io_dout, 32'h0);
    chk("idle_ack0", ack0, 1'b0);
    chk("idle_ack1", ack1, 1'b0);
    chk("idle_gnt", gnt, gnt_m);
    chk("idle_rdata0", rdata0, exp_rd[0]);
    chk("idle_rdata1", rdata1, exp_rd[1]);
  endtask

  // Called at an IDLE sample point; mode 0 keeps the winner requesting, 1 drops it, 2 randomizes.
  task automatic serve(input int mode);
    int w;
    check_idle();
    if (!p[0] && !p[1]) begin
      @(posedge clk); #1;
      lock_act = 1'b0;
      if (mode == 2) begin
        if ($urandom_range(0, 1) == 1) new_req(0);
        if ($urandom_range(0, 1) == 1) new_req(1);
      end
      return;
    end
    if (lock_act && p[last_m]) w = last_m;
    else if (p[0] && p[1])     w = 1 - last_m;
    else                       w = p[1] ? 1 : 0;

    @(posedge clk); #1;
    chk("xfer_busy", busy, 1'b1);
    chk("xfer_gnt", gnt, w);
    chk("xfer_addr", io_addr, a[w]);
    chk("xfer_dout", io_dout, wd[w]);
    chk("xfer_we", io_we, we_r[w]);
    chk("xfer_rd", io_rd, rd_r[w] & ~we_r[w]);
    chk("xfer_ack0", ack0, 1'b0);
    chk("xfer_ack1", ack1, 1'b0);
    if (rd_r[w] && !we_r[w]) exp_rd[w] = din_force ? din_val : periph(a[w]);
    if (mode == 2 && !p[1 - w] && $urandom_range(0, 1) == 1) new_req(1 - w);

    @(posedge clk); #1;
    chk("done_ack0", ack0, w == 0);
    chk("done_ack1", ack1, w == 1);
    chk("done_busy", busy, 1'b1);
    chk("done_we", io_we, 1'b0);
    chk("done_rd", io_rd, 1'b0);
    chk("done_addr", io_addr, 8'h0);
    chk("done_rdata0", rdata0, exp_rd[0]);
    chk("done_rdata1", rdata1, exp_rd[1]);
    last_m = w;
    gnt_m  = w[0];
    if (mode == 1) p[w] = 1'b0;
    else if (mode == 2) begin
      if ($urandom_range(0, 3) == 0) p[w] = 1'b0;
      else new_req(w);
    end
`ifdef IO_ARB_LOCK_EN
    lock_act = lk[w];
`else
    lock_act = 1'b0;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0;
    din_force = 1'b0; din_val = '0;
    for (int r = 0; r < 2; r++) begin
      p[r] = 0; a[r] = 0; wd[r] = 0; we_r[r] = 0; rd_r[r] = 0; lk[r] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle();
    rstn = 1'b1;

    // single write from requester 0
    set_req(0, 8'h00, 32'h0000_A5A5, 1'b1, 1'b0, 1'b0);
    serve(1);

    // read for requester 1 with a fixed peripheral value
    set_req(1, 8'h14, 32'h0, 1'b0, 1'b1, 1'b0);
    din_force = 1'b1; din_val = 32'h0000_1234;
    serve(1);
    din_force = 1'b0;
    chk("rdata1_1234", rdata1, 32'h0000_1234);

    // write and read both set: write wins
    set_req(0, 8'h18, 32'hDEAD_0018, 1'b1, 1'b1, 1'b0);
    serve(1);

    // both held: alternation
    set_req(0, 8'h21, 32'h1111_0000, 1'b0, 1'b1, 1'b0);
    set_req(1, 8'h42, 32'h2222_0000, 1'b1, 1'b0, 1'b0);
    repeat (4) serve(0);

    // lock hint on requester 0, then released
    lk[0] = 1'b1;
    repeat (3) serve(0);
    lk[0] = 1'b0;
    repeat (2) serve(0);
    p[0] = 1'b0; p[1] = 1'b0;
    serve(1);

    // reset in the middle of a transfer
    set_req(0, 8'h33, 32'hCAFE_0033, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_we", io_we, 1'b1);
    rstn = 1'b0;
    #1;
    model_reset();
    p[0] = 1'b0;
    chk("rst_we", io_we, 1'b0);
    chk("rst_rd", io_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", io_addr, 8'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    @(posedge clk); #1;
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_hold_busy", busy, 1'b0);
    rstn = 1'b1;
    set_req(0, 8'h35, 32'hBEEF_0035, 1'b1, 1'b0, 1'b0);
    serve(1);

    // randomized traffic
    new_req(0);
    new_req(1);
    repeat (250) serve(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
